// File: rtl/de_scoreboard_stage.sv
// de_scoreboard_stage: LC-3b decode stage with per-register pending-write counters,
// optional writeback bypass and the AGEX input latch.
module de_scoreboard_stage #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter int CS_W     = 20,
    parameter int MAX_INFL = 3,
    parameter int FWD_EN   = 0,
    localparam int RID_W   = $clog2(NREG),
    localparam int CNT_W   = $clog2(MAX_INFL + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de_v,
    input  logic [DATA_W-1:0] de_npc,
    input  logic [RID_W-1:0]  de_sr1_id,
    input  logic [RID_W-1:0]  de_sr2_id,
    input  logic              de_sr1_needed,
    input  logic              de_sr2_needed,
    input  logic [RID_W-1:0]  de_dr_id,
    input  logic              de_ld_reg,
    input  logic              de_ld_cc,
    input  logic              de_br_op,
    input  logic              de_br_stall,
    input  logic [CS_W-1:0]   de_cs,
    input  logic              mem_stall,
    input  logic              wb_v,
    input  logic [RID_W-1:0]  wb_dr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_ld_cc,
    input  logic [2:0]        wb_cc,
    output logic              dep_stall,
    output logic              ld_de,
    output logic              v_de_br_stall,
    output logic              agex_v,
    output logic [DATA_W-1:0] agex_npc,
    output logic [DATA_W-1:0] agex_sr1,
    output logic [DATA_W-1:0] agex_sr2,
    output logic [RID_W-1:0]  agex_drid,
    output logic              agex_ld_reg,
    output logic              agex_ld_cc,
    output logic [CS_W-1:0]   agex_cs,
    output logic [2:0]        agex_cc,
    output logic              sb_err
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_INFL);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic FWD = FWD_EN != 0;

    logic [DATA_W-1:0] rf [NREG];
    logic [CNT_W-1:0]  cnt [NREG];
    logic [CNT_W-1:0]  cc_cnt;
    logic [2:0]        cc;
    logic [NREG-1:0]   pend, reg_inc, reg_dec, reg_uf;
    logic              cc_pend, cc_inc, cc_dec, cc_uf, issue;
    logic [DATA_W-1:0] sr1_data, sr2_data;
    logic [2:0]        cc_data;

    // A writeback retiring the last outstanding write clears the pending state early when bypassing.
    always_comb begin
        pend = '0;
        reg_inc = '0;
        reg_dec = '0;
        reg_uf = '0;
        for (int i = 0; i < NREG; i++) begin
            pend[i] = cnt[i] != '0 && !(FWD && wb_v && wb_dr == RID_W'(i) && cnt[i] == ONE);
            reg_inc[i] = issue && de_ld_reg && de_dr_id == RID_W'(i);
            reg_dec[i] = wb_v && wb_dr == RID_W'(i);
            reg_uf[i] = reg_dec[i] && !reg_inc[i] && cnt[i] == '0;
        end
    end

    assign cc_pend = cc_cnt != '0 && !(FWD && wb_ld_cc && cc_cnt == ONE);
    assign cc_inc = issue & de_ld_cc;
    assign cc_dec = wb_ld_cc;
    assign cc_uf = cc_dec & ~cc_inc & (cc_cnt == '0);

    assign dep_stall = de_v & ((de_sr1_needed & pend[de_sr1_id]) | (de_sr2_needed & pend[de_sr2_id]) |
                               (de_br_op & cc_pend) | (de_ld_reg & (cnt[de_dr_id] == FULL)) |
                               (de_ld_cc & (cc_cnt == FULL)));
    assign ld_de = ~dep_stall & ~mem_stall;
    assign v_de_br_stall = de_v & de_br_stall;
    assign issue = de_v & ~dep_stall & ~mem_stall;

    assign sr1_data = (FWD && wb_v && wb_dr == de_sr1_id) ? wb_data : rf[de_sr1_id];
    assign sr2_data = (FWD && wb_v && wb_dr == de_sr2_id) ? wb_data : rf[de_sr2_id];
    assign cc_data = (FWD && wb_ld_cc) ? wb_cc : cc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
                cnt[i] <= '0;
            end
            cc <= 3'b010;
            cc_cnt <= '0;
            sb_err <= 1'b0;
            agex_v <= 1'b0;
            agex_npc <= '0;
            agex_sr1 <= '0;
            agex_sr2 <= '0;
            agex_drid <= '0;
            agex_ld_reg <= 1'b0;
            agex_ld_cc <= 1'b0;
            agex_cs <= '0;
            agex_cc <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_inc[i] && !reg_dec[i]) cnt[i] <= cnt[i] + ONE;
                else if (reg_dec[i] && !reg_inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - ONE;
            end
            if (cc_inc && !cc_dec) cc_cnt <= cc_cnt + ONE;
            else if (cc_dec && !cc_inc && cc_cnt != '0) cc_cnt <= cc_cnt - ONE;
            if (|reg_uf || cc_uf) sb_err <= 1'b1;
            if (wb_v) rf[wb_dr] <= wb_data;
            if (wb_ld_cc) cc <= wb_cc;
            if (!mem_stall) begin
                agex_v <= de_v & ~dep_stall;
                agex_npc <= de_npc;
                agex_sr1 <= sr1_data;
                agex_sr2 <= sr2_data;
                agex_drid <= de_dr_id;
                agex_ld_reg <= de_ld_reg;
                agex_ld_cc <= de_ld_cc;
                agex_cs <= de_cs;
                agex_cc <= cc_data;
            end
        end
    end
endmodule

// File: tb/tb_de_scoreboard_stage.sv
// tb_de_scoreboard_stage: drives a non-bypassing and a bypassing instance with the same
// stimulus and checks both against hand-computed expectations.
module tb_de_scoreboard_stage;
    logic clk = 1'b0;
    logic reset;
    logic de_v, de_sr1_needed, de_sr2_needed, de_ld_reg, de_ld_cc, de_br_op, de_br_stall;
    logic mem_stall, wb_v, wb_ld_cc;
    logic [15:0] de_npc, wb_data;
    logic [2:0] de_sr1_id, de_sr2_id, de_dr_id, wb_dr, wb_cc;
    logic [19:0] de_cs;

    logic dep_stall0, ld_de0, vbr0, agex_v0, agex_ld_reg0, agex_ld_cc0, sb_err0;
    logic dep_stall1, ld_de1, vbr1, agex_v1, agex_ld_reg1, agex_ld_cc1, sb_err1;
    logic [15:0] agex_npc0, agex_sr1_0, agex_sr2_0, agex_npc1, agex_sr1_1, agex_sr2_1;
    logic [2:0] agex_drid0, agex_cc0, agex_drid1, agex_cc1;
    logic [19:0] agex_cs0, agex_cs1;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    de_scoreboard_stage #(.FWD_EN(0)) dut0 (
        .clk(clk), .reset(reset), .de_v(de_v), .de_npc(de_npc), .de_sr1_id(de_sr1_id),
        .de_sr2_id(de_sr2_id), .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed),
        .de_dr_id(de_dr_id), .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op),
        .de_br_stall(de_br_stall), .de_cs(de_cs), .mem_stall(mem_stall), .wb_v(wb_v),
        .wb_dr(wb_dr), .wb_data(wb_data), .wb_ld_cc(wb_ld_cc), .wb_cc(wb_cc),
        .dep_stall(dep_stall0), .ld_de(ld_de0), .v_de_br_stall(vbr0), .agex_v(agex_v0),
        .agex_npc(agex_npc0), .agex_sr1(agex_sr1_0), .agex_sr2(agex_sr2_0),
        .agex_drid(agex_drid0), .agex_ld_reg(agex_ld_reg0), .agex_ld_cc(agex_ld_cc0),
        .agex_cs(agex_cs0), .agex_cc(agex_cc0), .sb_err(sb_err0));

    de_scoreboard_stage #(.FWD_EN(1)) dut1 (
        .clk(clk), .reset(reset), .de_v(de_v), .de_npc(de_npc), .de_sr1_id(de_sr1_id),
        .de_sr2_id(de_sr2_id), .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed),
        .de_dr_id(de_dr_id), .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op),
        .de_br_stall(de_br_stall), .de_cs(de_cs), .mem_stall(mem_stall), .wb_v(wb_v),
        .wb_dr(wb_dr), .wb_data(wb_data), .wb_ld_cc(wb_ld_cc), .wb_cc(wb_cc),
        .dep_stall(dep_stall1), .ld_de(ld_de1), .v_de_br_stall(vbr1), .agex_v(agex_v1),
        .agex_npc(agex_npc1), .agex_sr1(agex_sr1_1), .agex_sr2(agex_sr2_1),
        .agex_drid(agex_drid1), .agex_ld_reg(agex_ld_reg1), .agex_ld_cc(agex_ld_cc1),
        .agex_cs(agex_cs1), .agex_cc(agex_cc1), .sb_err(sb_err1));

    typedef struct packed {
        logic dv;
        logic [2:0] s1;
        logic n1;
        logic [2:0] s2;
        logic n2;
        logic [2:0] dr;
        logic lr, lc, br, wv;
        logic [2:0] wdr;
        logic [15:0] wd;
        logic wc;
        logic [2:0] wcc;
        logic st0, st1, v0, v1;
        logic [15:0] a0, a1;
        logic [2:0] c0, c1;
        logic err;
    } vec_t;

    vec_t tv [27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr();
        de_v = 0; de_npc = 0; de_sr1_id = 0; de_sr2_id = 0; de_sr1_needed = 0; de_sr2_needed = 0;
        de_dr_id = 0; de_ld_reg = 0; de_ld_cc = 0; de_br_op = 0; de_br_stall = 0; de_cs = 0;
        mem_stall = 0; wb_v = 0; wb_dr = 0; wb_data = 0; wb_ld_cc = 0; wb_cc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        dv s1 n1 s2 n2 dr lr lc br wv wdr wd       wc wcc st0 st1 v0 v1 a0       a1       c0 c1 err
        tv[0]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[1]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[3]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 16'h1234, 0, 0,  1, 0, 0, 1, 16'h0,    16'h1234, 2, 2, 0};
        tv[4]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h1234, 16'h1234, 2, 2, 0};
        tv[5]  = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[6]  = '{1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[7]  = '{1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 16'h0044, 0, 0,  0, 0, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[9]  = '{1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[10] = tv[9];
        tv[11] = tv[9];
        tv[12] = '{1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h2222, 0, 0,  0, 0, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[14] = '{1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 2, 16'h2222, 0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[15] = tv[9];
        tv[16] = tv[12];
        tv[17] = tv[13];
        tv[18] = tv[13];
        tv[19] = tv[13];
        tv[20] = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h2222, 16'h2222, 2, 2, 0};
        tv[21] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    2, 2, 0};
        tv[22] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,    2, 2, 0};
        tv[23] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0,    1, 4,  1, 0, 0, 1, 16'h0,    16'h0,    2, 4, 0};
        tv[24] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h0,    16'h0,    4, 4, 0};
        tv[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 16'h5555, 0, 0,  0, 0, 0, 0, 16'h0,    16'h0,    4, 4, 1};
        tv[26] = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 0,  0, 0, 1, 1, 16'h5555, 16'h5555, 4, 4, 1};

        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst agex_v", agex_v0, 0);
        chk("rst agex_cc", agex_cc0, 0);
        chk("rst sb_err", sb_err0, 0);
        reset = 0;

        for (int i = 0; i < 27; i++) begin
            de_v = tv[i].dv; de_sr1_id = tv[i].s1; de_sr1_needed = tv[i].n1;
            de_sr2_id = tv[i].s2; de_sr2_needed = tv[i].n2; de_dr_id = tv[i].dr;
            de_ld_reg = tv[i].lr; de_ld_cc = tv[i].lc; de_br_op = tv[i].br; de_br_stall = tv[i].br;
            wb_v = tv[i].wv; wb_dr = tv[i].wdr; wb_data = tv[i].wd; wb_ld_cc = tv[i].wc; wb_cc = tv[i].wcc;
            de_npc = 16'h3000 + 16'(i);
            #2;
            chk($sformatf("v%0d dep_stall0", i), dep_stall0, tv[i].st0);
            chk($sformatf("v%0d dep_stall1", i), dep_stall1, tv[i].st1);
            chk($sformatf("v%0d ld_de0", i), ld_de0, !tv[i].st0);
            chk($sformatf("v%0d v_de_br_stall", i), vbr0, tv[i].dv & tv[i].br);
            step();
            chk($sformatf("v%0d agex_v0", i), agex_v0, tv[i].v0);
            chk($sformatf("v%0d agex_v1", i), agex_v1, tv[i].v1);
            chk($sformatf("v%0d agex_sr1_0", i), agex_sr1_0, tv[i].a0);
            chk($sformatf("v%0d agex_sr1_1", i), agex_sr1_1, tv[i].a1);
            chk($sformatf("v%0d agex_cc0", i), agex_cc0, tv[i].c0);
            chk($sformatf("v%0d agex_cc1", i), agex_cc1, tv[i].c1);
            chk($sformatf("v%0d sb_err0", i), sb_err0, tv[i].err);
            chk($sformatf("v%0d sb_err1", i), sb_err1, tv[i].err);
            chk($sformatf("v%0d agex_npc0", i), agex_npc0, 32'h3000 + i);
        end

        // mem_stall hold with a dependency stall and a writeback in the same cycle
        clr();
        de_v = 1; de_dr_id = 7; de_ld_reg = 1; de_npc = 16'h7777;
        step();
        chk("ms setup drid", agex_drid0, 7);
        chk("ms setup ld_reg", agex_ld_reg0, 1);
        chk("ms setup npc", agex_npc0, 16'h7777);
        clr();
        de_v = 1; de_sr1_id = 7; de_sr1_needed = 1; de_dr_id = 6; de_ld_reg = 1; de_npc = 16'hABCD;
        mem_stall = 1; wb_v = 1; wb_dr = 7; wb_data = 16'h7070;
        #2;
        chk("ms dep_stall0", dep_stall0, 1);
        chk("ms dep_stall1", dep_stall1, 0);
        chk("ms ld_de1", ld_de1, 0);
        step();
        wb_v = 0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ms hold%0d agex_v", c), agex_v0, 1);
            chk($sformatf("ms hold%0d npc", c), agex_npc0, 16'h7777);
            chk($sformatf("ms hold%0d drid", c), agex_drid1, 7);
            if (c < 2) begin
                #2;
                chk($sformatf("ms hold%0d dep_stall0", c), dep_stall0, 0);
                step();
            end
        end
        clr();
        de_v = 1; de_sr1_id = 6; de_sr1_needed = 1; de_sr2_id = 7; de_sr2_needed = 1;
        #2;
        chk("ms release dep_stall0", dep_stall0, 0);
        chk("ms release dep_stall1", dep_stall1, 0);
        step();
        chk("ms release agex_v", agex_v0, 1);
        chk("ms release agex_sr2", agex_sr2_0, 16'h7070);

        // asynchronous reset in the middle of operation
        clr();
        de_v = 1; de_dr_id = 3; de_ld_reg = 1; de_ld_cc = 1; de_cs = 20'hABCDE;
        step();
        chk("rr agex_cs", agex_cs0, 20'hABCDE);
        chk("rr agex_ld_cc", agex_ld_cc1, 1);
        clr();
        #2;
        reset = 1;
        #1;
        chk("rr async agex_v", agex_v0, 0);
        chk("rr async agex_cs", agex_cs0, 0);
        chk("rr async sb_err", sb_err0, 0);
        step();
        reset = 0;
        de_v = 1; de_sr1_id = 3; de_sr1_needed = 1; de_br_op = 1;
        #2;
        chk("rr cnt cleared", dep_stall0, 0);
        step();
        chk("rr agex_v", agex_v0, 1);
        chk("rr agex_cc", agex_cc0, 3'b010);
        clr();
        wb_v = 1; wb_dr = 3; wb_data = 16'h0303;
        step();
        chk("rr underflow sb_err0", sb_err0, 1);
        chk("rr underflow sb_err1", sb_err1, 1);
        clr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
